mem_arbiter: RTL

Two-requester arbiter that shares the single `Data_Memory` port (256-bit line, enable/write/ack handshake) between the instruction cache (requester 0) and the data cache (requester 1). It sits between the two cache controllers and `Data_Memory` inside `CPU`. It grants one line transfer at a time using round-robin, holds the grant until memory acknowledges, and returns the line and a one-cycle ack to the winner. A watchdog aborts transfers that never complete.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_pick2.sv | 31 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
//
// Contents:
//   DEF_LINE_W / DEF_ADDR_W / DEF_TIMEOUT : default parameter values
//   state_t                               : arbiter FSM state encoding
//   grant_idx_t                           : index of the granted requester
package mem_arb_pkg;

  localparam int DEF_LINE_W  = 256;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // One bit is enough for two requesters; widen this for an N-way picker.
  typedef logic grant_idx_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
//
// Ports:
//   req0, req1  : request lines of requester 0 and 1
//   last_grant  : index granted most recently
//   grant_valid : at least one request is pending
//   grant_idx   : winner; only meaningful while grant_valid is high
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  grant_idx_t last_grant,
  output logic       grant_valid,
  output grant_idx_t grant_idx
);

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      // Contention: the requester that did not win last time goes first.
      grant_idx = ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the instruction cache
// (requester 0) and the data cache (requester 1). One transfer at a time,
// round-robin between requesters, grant held until memory acknowledges,
// watchdog aborts a transfer that never completes.
//
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   r0_*/r1_* req/write/addr/data inputs : requests, held until ack
//   r0_ack_o/r1_ack_o         : one-cycle completion pulse to the winner
//   r0_data_o/r1_data_o       : last line captured for that requester
//   mem_enable/write/addr/data_o : registered memory request
//   mem_ack_i, mem_data_i     : memory completion pulse and read line
//   timeout_o                 : sticky watchdog abort flag
//
// TIMEOUT must be greater than 1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              r0_req_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [LINE_W-1:0] r0_data_i,
  input  logic              r1_req_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [LINE_W-1:0] r1_data_i,
  output logic              r0_ack_o,
  output logic [LINE_W-1:0] r0_data_o,
  output logic              r1_ack_o,
  output logic [LINE_W-1:0] r1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              timeout_o
);

  localparam int              CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state;
  grant_idx_t        last_grant;
  grant_idx_t        grant;
  logic [CNT_W-1:0]  cnt;

  logic              pick_valid;
  grant_idx_t        pick_idx;
  logic              finish;
  logic [LINE_W-1:0] resp_line;

  rr_pick2 u_pick (
    .req0        (r0_req_i),
    .req1        (r1_req_i),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  // A real ack beats the watchdog when both land in the same cycle; an
  // aborted transfer returns an all-zero line.
  assign finish    = mem_ack_i || (cnt == CNT_MAX);
  assign resp_line = mem_ack_i ? mem_data_i : '0;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      last_grant   <= 1'b1;  // requester 0 wins the first contention
      grant        <= 1'b0;
      cnt          <= '0;
      r0_ack_o     <= 1'b0;
      r1_ack_o     <= 1'b0;
      r0_data_o    <= '0;
      r1_data_o    <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      timeout_o    <= 1'b0;
    end else begin
      r0_ack_o <= 1'b0;
      r1_ack_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state        <= BUSY;
            grant        <= pick_idx;
            last_grant   <= pick_idx;
            cnt          <= '0;
            mem_enable_o <= 1'b1;
            // Latched copy drives memory; later request changes are ignored.
            mem_write_o  <= pick_idx ? r1_write_i : r0_write_i;
            mem_addr_o   <= pick_idx ? r1_addr_i  : r0_addr_i;
            mem_data_o   <= pick_idx ? r1_data_i  : r0_data_i;
          end
        end
        BUSY: begin
          if (finish) begin
            state        <= RESP;
            mem_enable_o <= 1'b0;
            if (!mem_ack_i) timeout_o <= 1'b1;
            if (grant) begin
              r1_ack_o  <= 1'b1;
              r1_data_o <= resp_line;
            end else begin
              r0_ack_o  <= 1'b1;
              r0_data_o <= resp_line;
            end
          end else begin
            // Saturates at CNT_MAX by construction: reaching it ends BUSY.
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_arbiter
